button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-input time in clocks (20 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 15000000, clocks from the first move pulse to the first auto-repeat pulse (300 ms).
REQ-003 Parameter REPEAT_PERIOD, default 5000000, clocks between auto-repeat pulses (100 ms).
REQ-004 clk  in  1  single system clock, 50 MHz.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 izq  in  1  raw left button, asynchronous, active-high.
REQ-007 der  in  1  raw right button, asynchronous, active-high.
REQ-008 fire  in  1  raw fire button, asynchronous, active-high.
REQ-009 izq_move  out  1  one-cycle left-step strobe to the game core.
REQ-010 der_move  out  1  one-cycle right-step strobe to the game core.
REQ-011 fire_pulse  out  1  one-cycle shot strobe to the game core.
REQ-012 btn_level  out  3  debounced levels {fire, der, izq}, for LED display.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Per button, a debounce counter SHALL clear whenever the synchronized value equals the stable level, and SHALL otherwise increment; stable SHALL take the synchronized value on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES clocks SHALL never change stable; the counter SHALL restart from 0 on every bounce.
REQ-016 Latency from a clean raw rising edge to the first strobe SHALL be exactly DEBOUNCE_CYCLES+3 clocks (2 sync, DEBOUNCE_CYCLES debounce, 1 registered strobe); release latency to btn_level SHALL be DEBOUNCE_CYCLES+2 clocks.
REQ-017 fire_pulse SHALL be high for exactly one cycle per stable rising edge of fire, with no auto-repeat while fire is held.
REQ-018 Each direction SHALL have a 3-state FSM: IDLE, DELAY, REPEAT, plus a repeat counter sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-019 IDLE: on a stable rise, emit one move strobe, clear the counter, go to DELAY.
REQ-020 DELAY: on a stable low, go to IDLE; on counter = REPEAT_DELAY-1, emit a strobe, clear the counter, go to REPEAT.
REQ-021 REPEAT: on a stable low, go to IDLE; on counter = REPEAT_PERIOD-1, emit a strobe and clear the counter.
REQ-022 Release SHALL take priority over a terminal count in the same cycle (no strobe).
REQ-023 While both izq and der are stable high, izq_move and der_move SHALL both be forced 0; the FSMs keep running, and strobes resume on the next terminal count after one button releases.
REQ-024 fire strobes SHALL be independent of direction activity; simultaneous move and fire strobes are legal.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 Reset SHALL clear synchronizers, stable levels, and counters to 0, put both FSMs in IDLE, and drive all outputs to 0 immediately.
REQ-027 A button held through reset deassertion SHALL be treated as a new press: one strobe at DEBOUNCE_CYCLES+3 clocks after reset falls.
REQ-028 Reset asserted mid-DELAY or mid-REPEAT SHALL abort without emitting a strobe.

Structure
REQ-029 A shared constants package SHALL hold the 50 MHz clock rate, the default timing values, and the FSM state encodings, also used by the game core.
REQ-030 Sub-module debounce_cell (synchronizer, debounce counter, stable level, rise strobe) SHALL be instantiated three times; the repeat FSMs live in the top.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4)
REQ-031 fire high for 40 clocks -> fire_pulse high exactly once, at clock 7 after the edge; btn_level[2] high from clock 6 until clock 6 after release.
REQ-032 izq bouncing 0/1 every 2 clocks for 20 clocks, then held -> no strobe during the bounce; one izq_move 7 clocks after the final rise.
REQ-033 izq held 30 clocks -> izq_move strobes at t=7, 15, 19, 23, 27; none after release.
REQ-034 izq held, der pressed at t=10 -> no move strobes while both are stable; releasing der resumes izq_move on the next REPEAT terminal count.
REQ-035 Reset pulsed at t=12 during an izq hold -> outputs 0 at once; the next izq_move arrives 7 clocks after reset falls.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button front end and the game core: clock rate,
// default debounce/auto-repeat timing and the repeat FSM state encoding.
package button_conditioner_pkg;

  localparam int CLK_HZ                = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES   = 1_000_000;   // 20 ms
  localparam int DEF_REPEAT_DELAY      = 15_000_000;  // 300 ms
  localparam int DEF_REPEAT_PERIOD     = 5_000_000;   // 100 ms

  // Button bit positions inside the {fire, der, izq} vectors.
  localparam int BTN_IZQ  = 0;
  localparam int BTN_DER  = 1;
  localparam int BTN_FIRE = 2;
  localparam int NUM_BTN  = 3;
  localparam int NUM_DIR  = 2;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Counter width able to hold 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// One button: 2-flop synchronizer, debounce counter, stable level and a
// registered one-cycle rise flag aligned with the level change.
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          flip;

  assign differ = (sync[1] != level);
  assign flip   = differ && (cnt == TERM);

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], raw};
  end

  // Count consecutive disagreeing cycles; any bounce back restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (!differ || flip) begin
      cnt   <= '0;
      if (flip) level <= sync[1];
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Rise flag is high on the first cycle the stable level reads 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rise <= 1'b0;
    else       rise <= flip && sync[1];
  end

endmodule

// File: rtl/button_conditioner.sv
// Button front end: three debounce cells, auto-repeat FSMs for the two
// direction buttons and registered strobes toward the game core.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       izq,
  input  logic       der,
  input  logic       fire,
  output logic       izq_move,
  output logic       der_move,
  output logic       fire_pulse,
  output logic [2:0] btn_level
);

  localparam int             RCW     = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RCW-1:0] RD_TERM = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RP_TERM = RCW'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] raw_in;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_DIR-1:0] dir_strobe;
  logic               both_held;

  assign raw_in    = {fire, der, izq};
  assign btn_level = level;
  assign both_held = level[BTN_IZQ] & level[BTN_DER];

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_cell
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_in[b]),
      .level (level[b]),
      .rise  (rise[b])
    );
  end

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    rpt_state_t     state, state_nxt;
    logic [RCW-1:0] cnt, cnt_nxt;
    logic           strobe;

    // Repeat FSM state and its delay/period counter.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= RPT_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // Press -> strobe, wait REPEAT_DELAY, then strobe every REPEAT_PERIOD;
    // release wins over a terminal count landing in the same cycle.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      strobe    = 1'b0;
      case (state)
        RPT_IDLE: begin
          cnt_nxt = '0;
          if (rise[d]) begin
            strobe    = 1'b1;
            state_nxt = RPT_DELAY;
          end
        end
        RPT_DELAY: begin
          if (!level[d]) begin
            state_nxt = RPT_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == RD_TERM) begin
            strobe    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RPT_REPEAT;
          end
        end
        RPT_REPEAT: begin
          if (!level[d]) begin
            state_nxt = RPT_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == RP_TERM) begin
            strobe    = 1'b1;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = RPT_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign dir_strobe[d] = strobe;
  end

  // Registered strobes; opposing directions held together cancel each other
  // while the FSMs keep their timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      izq_move   <= 1'b0;
      der_move   <= 1'b0;
      fire_pulse <= 1'b0;
    end else begin
      izq_move   <= dir_strobe[BTN_IZQ] & ~both_held;
      der_move   <= dir_strobe[BTN_DER] & ~both_held;
      fire_pulse <= rise[BTN_FIRE];
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: scripted and random button stimulus compared cycle by
// cycle against a schedule-based reference model of the conditioner.
module tb_button_conditioner;
  localparam int DEB  = 4;
  localparam int RD   = 8;
  localparam int RP   = 4;
  localparam int MAXN = 256;

  logic       clk = 1'b0, reset = 1'b0;
  logic       izq = 1'b0, der = 1'b0, fire = 1'b0;
  logic       izq_move, der_move, fire_pulse;
  logic [2:0] btn_level;

  int n_tests = 0;
  int n_fail  = 0;

  // stim[k]: raw {fire,der,izq} sampled at edge k (k=1 is the first edge
  // after reset release). obs/exp: {btn_level, fire_pulse, der_move, izq_move}.
  logic [2:0] stim  [0:MAXN];
  logic [5:0] obs   [0:MAXN];
  logic [5:0] exp_v [0:MAXN];
  logic       st    [0:2][0:MAXN];
  logic       str   [0:1][0:MAXN];

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .izq(izq), .der(der), .fire(fire),
    .izq_move(izq_move), .der_move(der_move), .fire_pulse(fire_pulse),
    .btn_level(btn_level)
  );

  task automatic clear_stim();
    for (int k = 0; k <= MAXN; k++) stim[k] = 3'b000;
  endtask

  // Reset (inputs keep their current values), release at a falling edge,
  // then play stim[1..n] and record outputs just after every rising edge.
  task automatic run(input int n);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    obs[0] = {btn_level, fire_pulse, der_move, izq_move};
    for (int k = 1; k <= n; k++) begin
      {fire, der, izq} = stim[k];
      @(posedge clk);
      #1 obs[k] = {btn_level, fire_pulse, der_move, izq_move};
      @(negedge clk);
    end
  endtask

  // Reference: a level flips once the synchronized input (raw delayed two
  // clocks) has disagreed with it for DEB consecutive cycles since the last
  // flip. Each rise schedules strobes at r+1, +RD, then every +RP for as long
  // as the level stays high.
  task automatic build_model(input int n);
    int  lc [0:2];
    bit  ok;
    int  f, t, step;
    logic s2;
    for (int b = 0; b < 3; b++) begin
      lc[b] = -1000;
      st[b][0] = 1'b0;
    end
    for (int k = 1; k <= n; k++) begin
      for (int b = 0; b < 3; b++) begin
        ok = (k - lc[b] >= DEB);
        for (int j = k - DEB; j < k; j++) begin
          s2 = (j <= 0) ? 1'b0 : stim[j-1][b];
          if (j < 0 || s2 == st[b][k-1]) ok = 1'b0;
        end
        st[b][k] = ok ? ~st[b][k-1] : st[b][k-1];
        if (ok) lc[b] = k;
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k <= n; k++) str[d][k] = 1'b0;
      for (int r = 1; r <= n; r++) begin
        if (st[d][r] && !st[d][r-1]) begin
          f = r + 1;
          while (f <= n && st[d][f]) f++;
          t = r + 1;
          step = RD;
          while (t <= n && t <= f) begin
            str[d][t] = 1'b1;
            t = t + step;
            step = RP;
          end
        end
      end
    end
    exp_v[0] = 6'b0;
    for (int k = 1; k <= n; k++) begin
      exp_v[k][5:3] = {st[2][k], st[1][k], st[0][k]};
      exp_v[k][2]   = (k >= 2) && st[2][k-1] && !st[2][k-2];
      exp_v[k][1]   = str[1][k] && !(st[0][k-1] && st[1][k-1]);
      exp_v[k][0]   = str[0][k] && !(st[0][k-1] && st[1][k-1]);
    end
  endtask

  task automatic test_reset();
    {fire, der, izq} = 3'b111;
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if ({btn_level, fire_pulse, der_move, izq_move} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b", {btn_level, fire_pulse, der_move, izq_move}, 6'b0);
    end
    {fire, der, izq} = 3'b000;
    clear_stim();
    run(10);
    build_model(10);
    for (int k = 0; k <= 10; k++) begin
      n_tests++;
      if (obs[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_fire();
    int cnt;
    clear_stim();
    for (int k = 1; k <= 40; k++) stim[k] = 3'b100;
    run(60);
    build_model(60);
    for (int k = 0; k <= 60; k++) begin
      n_tests++;
      if (obs[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL fire k=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
      end
    end
    cnt = 0;
    for (int k = 0; k <= 60; k++) cnt += int'(obs[k][2]);
    n_tests++;
    if (cnt != 1 || obs[7][2] !== 1'b1) begin
      n_fail++;
      $display("FAIL fire_once count=%0d at7=%b exp count=1 at7=1", cnt, obs[7][2]);
    end
    n_tests++;
    if ({obs[5][5], obs[6][5], obs[45][5], obs[46][5]} !== 4'b0110) begin
      n_fail++;
      $display("FAIL fire_level got=%b exp=0110", {obs[5][5], obs[6][5], obs[45][5], obs[46][5]});
    end
  endtask

  task automatic test_bounce();
    clear_stim();
    for (int k = 1; k <= 20; k++) stim[k] = (((k - 1) / 2) % 2 == 0) ? 3'b001 : 3'b000;
    for (int k = 21; k <= 45; k++) stim[k] = 3'b001;
    run(45);
    build_model(45);
    for (int k = 0; k <= 45; k++) begin
      n_tests++;
      if (obs[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL bounce k=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
      end
    end
    n_tests++;
    if (obs[27][0] !== 1'b1 || obs[26][0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_first at26=%b at27=%b exp 0 1", obs[26][0], obs[27][0]);
    end
  endtask

  task automatic test_repeat();
    clear_stim();
    for (int k = 1; k <= 30; k++) stim[k] = 3'b001;
    run(50);
    build_model(50);
    for (int k = 0; k <= 50; k++) begin
      n_tests++;
      if (obs[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL repeat k=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
      end
    end
    n_tests++;
    if ({obs[7][0], obs[15][0], obs[19][0], obs[23][0], obs[27][0], obs[8][0], obs[14][0]} !== 7'b1111100) begin
      n_fail++;
      $display("FAIL repeat_times got=%b exp=1111100",
               {obs[7][0], obs[15][0], obs[19][0], obs[23][0], obs[27][0], obs[8][0], obs[14][0]});
    end
  endtask

  task automatic test_both();
    clear_stim();
    for (int k = 1; k <= 60; k++) stim[k] = 3'b001;
    for (int k = 10; k <= 30; k++) stim[k] = 3'b011;
    run(80);
    build_model(80);
    for (int k = 0; k <= 80; k++) begin
      n_tests++;
      if (obs[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL both k=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
      end
    end
    n_tests++;
    if ({obs[16][1], obs[23][0], obs[39][0]} !== 3'b001) begin
      n_fail++;
      $display("FAIL both_mask got=%b exp=001", {obs[16][1], obs[23][0], obs[39][0]});
    end
  endtask

  task automatic test_reset_mid();
    clear_stim();
    for (int k = 1; k <= 30; k++) stim[k] = 3'b001;
    run(12);
    build_model(12);
    for (int k = 0; k <= 12; k++) begin
      n_tests++;
      if (obs[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL reset_mid_pre k=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
      end
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({btn_level, fire_pulse, der_move, izq_move} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%b exp=%b", {btn_level, fire_pulse, der_move, izq_move}, 6'b0);
    end
    run(30);
    build_model(30);
    for (int k = 0; k <= 30; k++) begin
      n_tests++;
      if (obs[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL reset_mid_post k=%0d got=%b exp=%b", k, obs[k], exp_v[k]);
      end
    end
    n_tests++;
    if (obs[7][0] !== 1'b1 || obs[6][0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_first at6=%b at7=%b exp 0 1", obs[6][0], obs[7][0]);
    end
  endtask

  task automatic test_random();
    int   n, len;
    logic v;
    n = 200;
    for (int round = 0; round < 4; round++) begin
      clear_stim();
      for (int b = 0; b < 3; b++) begin
        int k;
        k = 1;
        v = 1'b0;
        while (k <= n) begin
          len = (($urandom % 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(3, 30));
          for (int i = 0; i < len && k <= n; i++) begin
            stim[k][b] = v;
            k++;
          end
          v = ~v;
        end
      end
      {fire, der, izq} = 3'b000;
      run(n);
      build_model(n);
      for (int k = 0; k <= n; k++) begin
        n_tests++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL random r=%0d k=%0d got=%b exp=%b", round, k, obs[k], exp_v[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fire();
    test_bounce();
    test_repeat();
    test_both();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
